timer_counter: RTL and testbench

//  Memory-mapped countdown timer. It is the responder on the CPU data-memory store/load

---
 rtl/timer_counter_if.sv | 17 +
 rtl/timer_counter.sv | 139 +++++++++++++
 tb/tb_timer_counter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Bus bundle between the system bridge and the countdown timer.
//   addr  word offset inside the timer window (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//   we    write strobe, sampled at the rising clock edge
//   din   write data
//   dout  combinational read data for the current addr
//   irq   interrupt request to the CPU
// master: bridge side (drives addr/we/din); slave: timer side (drives dout/irq).
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   io_bus   slave side of timer_counter_if (addr/we/din in, dout/irq out)
// Register map: CTRL = {IM, MODE[1:0], EN}, PRESET (RW), COUNT (RO), reserved (reads 0).
module timer_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    timer_counter_if.slave io_bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irq_flag;
    logic             r_autoclr;   // set for the cycle after an auto-reload expiry

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_ctrl_nxt;
    logic [CNT_W-1:0] w_preset_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_irq_flag_nxt;
    logic             w_autoclr_nxt;

    logic             w_en;
    logic             w_reload;
    logic             w_ctrl_wr;
    logic             w_preset_wr;
    logic [31:0]      w_dout;
    logic             w_unused_din;

    assign w_en        = r_ctrl[0];
    assign w_reload    = (r_ctrl[2:1] == 2'b01);  // MODE 1x behaves as one-shot
    assign w_ctrl_wr   = io_bus.we && (io_bus.addr == 2'd0);
    assign w_preset_wr = io_bus.we && (io_bus.addr == 2'd1);

    // Bits of din above CNT_W are dropped on PRESET writes.
    assign w_unused_din = ^io_bus.din;

    always_comb begin
        w_state_nxt    = r_state;
        w_ctrl_nxt     = r_ctrl;
        w_preset_nxt   = r_preset;
        w_count_nxt    = r_count;
        w_irq_flag_nxt = r_irq_flag;
        w_autoclr_nxt  = 1'b0;

        if (r_autoclr) begin
            w_irq_flag_nxt = 1'b0;
        end

        // CPU writes; addr 2 and 3 are ignored.
        if (w_ctrl_wr) begin
            w_ctrl_nxt     = io_bus.din[3:0];
            w_irq_flag_nxt = 1'b0;
        end
        if (w_preset_wr) begin
            w_preset_nxt   = io_bus.din[CNT_W-1:0];
            w_irq_flag_nxt = 1'b0;
        end

        // FSM decisions use the registered CTRL, not the value being written.
        case (r_state)
            ST_IDLE: begin
                if (w_en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = ST_INT;
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            ST_INT: begin
                // Setting the flag overrides any clear from a same-cycle write.
                w_irq_flag_nxt = 1'b1;
                if (w_reload) begin
                    w_state_nxt   = ST_LOAD;
                    w_autoclr_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    // A CPU CTRL write in this cycle takes precedence over the EN auto-clear.
                    if (!w_ctrl_wr) begin
                        w_ctrl_nxt[0] = 1'b0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
            r_autoclr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_irq_flag_nxt;
            r_autoclr  <= w_autoclr_nxt;
        end
    end

    always_comb begin
        w_dout = 32'd0;
        case (io_bus.addr)
            2'd0:    w_dout = {28'd0, r_ctrl};
            2'd1:    w_dout = 32'(r_preset);
            2'd2:    w_dout = 32'(r_count);
            default: w_dout = 32'd0;
        endcase
    end

    assign io_bus.dout = w_dout;
    assign io_bus.irq  = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter. "Edge 0" in the comments is the edge at
// which the enabling CTRL write lands.
module tb_timer_counter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    timer_counter_if bus_if ();

    timer_counter #(.CNT_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.we   = 1'b1;
        bus_if.addr = a;
        bus_if.din  = d;
        @(posedge clk);
        #1;
        bus_if.we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1;
        d = bus_if.dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            n_vec++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, d);
            end
        end
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq got=%b exp=0", bus_if.irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(2);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd5) begin
            n_err++;
            $display("FAIL oneshot_load got=%0d exp=5", d);
        end
        for (int k = 1; k <= 5; k++) begin
            step(1);
            rd(2'd2, d);
            n_vec++;
            if (d !== 32'(5 - k)) begin
                n_err++;
                $display("FAIL oneshot_count step=%0d got=%0d exp=%0d", k, d, 5 - k);
            end
        end
        step(1);  // edge 8: INT entered, no irq yet
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_irq_early got=%b exp=0", bus_if.irq);
        end
        step(1);  // edge 9
        n_vec++;
        if (bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_irq_rise got=%b exp=1", bus_if.irq);
        end
        step(3);
        n_vec++;
        if (bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_irq_hold got=%b exp=1", bus_if.irq);
        end
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'h8) begin
            n_err++;
            $display("FAIL oneshot_ctrl got=%h exp=8", d);
        end
        wr(2'd0, 32'h8);
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", bus_if.irq);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic        exp;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        // Pulses after edges 6, 11, 16, 21.
        for (int e = 1; e <= 21; e++) begin
            step(1);
            exp = (e >= 6) && (((e - 6) % 5) == 0);
            n_vec++;
            if (bus_if.irq !== exp) begin
                n_err++;
                $display("FAIL reload_irq edge=%0d got=%b exp=%b", e, bus_if.irq, exp);
            end
        end
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'hB) begin
            n_err++;
            $display("FAIL reload_ctrl got=%h exp=b", d);
        end
        wr(2'd0, 32'h0);
        step(6);
    endtask

    task automatic test_stop_restart();
        logic [31:0] d;
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        step(8);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd4) begin
            n_err++;
            $display("FAIL stop_pre got=%0d exp=4", d);
        end
        wr(2'd0, 32'h0);  // lands on the edge that produces 3
        for (int k = 0; k < 20; k++) begin
            rd(2'd2, d);
            n_vec++;
            if (d !== 32'd3 || bus_if.irq !== 1'b0) begin
                n_err++;
                $display("FAIL stop_hold cyc=%0d count=%0d irq=%b exp count=3 irq=0",
                         k, d, bus_if.irq);
            end
            step(1);
        end
        wr(2'd0, 32'h9);
        step(1);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd3) begin
            n_err++;
            $display("FAIL restart_load_cycle got=%0d exp=3", d);
        end
        step(1);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd10) begin
            n_err++;
            $display("FAIL restart_reload got=%0d exp=10", d);
        end
        wr(2'd0, 32'h0);  // one more decrement lands, then stops at 9
        step(3);
    endtask

    task automatic test_reserved();
        logic [31:0] d;
        wr(2'd2, 32'hAA);
        wr(2'd3, 32'h5F);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd9) begin
            n_err++;
            $display("FAIL reserved_count got=%0d exp=9", d);
        end
        rd(2'd3, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reserved_read got=%h exp=0", d);
        end
        rd(2'd1, d);
        n_vec++;
        if (d !== 32'd10) begin
            n_err++;
            $display("FAIL reserved_preset got=%0d exp=10", d);
        end
    endtask

    task automatic test_masked_and_collision();
        logic [31:0] d;
        // IM=0: expiry stays invisible, and a later CTRL write clears the flag.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        step(6);
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL masked_irq got=%b exp=0", bus_if.irq);
        end
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL masked_ctrl_en_clr got=%h exp=0", d);
        end
        wr(2'd0, 32'h8);
        step(3);
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL masked_flag_cleared got=%b exp=0", bus_if.irq);
        end
        // CTRL write landing on the INT cycle: flag set wins over the write's clear.
        wr(2'd0, 32'h1);
        step(4);
        wr(2'd0, 32'h8);
        n_vec++;
        if (bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL collide_flag got=%b exp=1", bus_if.irq);
        end
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'h8) begin
            n_err++;
            $display("FAIL collide_ctrl got=%h exp=8", d);
        end
        step(2);
        n_vec++;
        if (bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL collide_hold got=%b exp=1", bus_if.irq);
        end
        // Written CTRL wins over the one-shot EN auto-clear.
        wr(2'd0, 32'h0);
        wr(2'd0, 32'h1);
        step(4);
        wr(2'd0, 32'h9);
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'h9 || bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL collide_en_wins ctrl=%h irq=%b exp ctrl=9 irq=1", d, bus_if.irq);
        end
        wr(2'd0, 32'h0);
        step(4);
    endtask

    task automatic test_preset_zero();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(3);
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL zero_irq_early got=%b exp=0", bus_if.irq);
        end
        step(1);
        n_vec++;
        if (bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL zero_irq_rise got=%b exp=1", bus_if.irq);
        end
        wr(2'd1, 32'd7);  // PRESET write also clears the flag
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL zero_preset_clr got=%b exp=0", bus_if.irq);
        end
        wr(2'd0, 32'h0);
        step(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        step(52);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd50) begin
            n_err++;
            $display("FAIL rstmid_pre got=%0d exp=50", d);
        end
        rst         = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.addr = 2'd0;
        bus_if.din  = 32'hF;
        step(1);
        bus_if.we = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd(a[1:0], d);
            n_vec++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL rstmid_read addr=%0d got=%h exp=0", a, d);
            end
        end
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_irq got=%b exp=0", bus_if.irq);
        end
        rst = 1'b0;
        step(10);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_norestart_count got=%0d exp=0", d);
        end
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_norestart_ctrl got=%h exp=0", d);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 2'd0;
        bus_if.din  = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_stop_restart();
        test_reserved();
        test_masked_and_collision();
        test_preset_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
